kernel_seq: RTL and testbench
=============================

KERNEL_SEQ -- requirements
Module: kernel_seq

Sequences the K-1 row buffers and the KxK shift window of the kernel datapath using pointer-muxed buffers: one buffer is written per row, and the window is fed in rotated order.

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3, kernel edge length K (3..7).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, stream word width.
REQ-003 SHALL have parameter MAX_COLS, default 1288, row buffer depth.
REQ-004 SHALL have parameter NUM_COLS_WIDTH, default 11, column address width.
REQ-005 SHALL have port clk  input  1  sole clock; one clock, and all state SHALL be rising-edge.
REQ-006 SHALL have port resetb  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port dvi  input  1  input word valid.
REQ-008 SHALL have port dtypei  input  `DTYPE_WIDTH  input word type.
REQ-009 SHALL have port datai  input  DATA_WIDTH  input word.
REQ-010 SHALL have port enable  input  1  0 = bypass.
REQ-011 SHALL have port col_addr  output  NUM_COLS_WIDTH  shared row buffer address.
REQ-012 SHALL have port buf_we  output  K-1  one-hot buffer write enable.
REQ-013 SHALL have port rd_base  output  3  index of oldest buffer, which feeds window row 0.
REQ-014 SHALL have port win_shift  output  1  shift the KxK window one column.
REQ-015 SHALL have port dvo  output  1  output word valid.
REQ-016 SHALL have port dtypeo  output  `DTYPE_WIDTH  output word type.
REQ-017 SHALL have port meta_datao  output  DATA_WIDTH  header-adjusted word.
REQ-018 SHALL have port err  output  2  sticky flags: bit0 protocol error, bit1 column overflow.

Function
REQ-019 SHALL implement states IDLE, FRAME and ROW; FRAME_START takes any state to FRAME, ROW_START takes FRAME to ROW, ROW_END takes ROW to FRAME, and FRAME_END takes any state to IDLE.
REQ-020 SHALL define a pixel beat as dvi & |(dtypei & `DTYPE_PIXEL_MASK) & enable & state==ROW.
REQ-021 SHALL drive buf_we combinationally to onehot(wr_ptr) on a pixel beat and to 0 otherwise.
REQ-022 SHALL drive win_shift combinationally equal to the pixel beat.
REQ-023 SHALL clear col_addr to 0 on ROW_START and increment it by 1 after each pixel beat.
REQ-024 SHALL saturate col_addr at MAX_COLS-1 and set err[1] when a pixel beat arrives at MAX_COLS-1.
REQ-025 SHALL clear wr_ptr and row_cnt on FRAME_START.
REQ-026 SHALL, on ROW_END, advance wr_ptr modulo K-1 and increment row_cnt, saturating at K-1.
REQ-027 SHALL drive rd_base as (wr_ptr+1) mod K-1.
REQ-028 SHALL compute valid_row = row_cnt >= K-1 and valid_col = col_addr >= K-1.
REQ-029 SHALL register dvo, dtypeo and meta_datao with a latency of 1 clock; dtypeo SHALL follow dtypei every cycle.
REQ-030 SHALL, when enabled, set dvo to dvi & valid_row for ROW_START and ROW_END, to dvi & valid_row & valid_col for pixels, to dvi for other types, and to 0 when dvi is low.
REQ-031 SHALL clear header_addr (6 bit) on HEADER_START and increment it on each HEADER word.
REQ-032 SHALL, when enabled and header_addr equals `Image_num_cols or `Image_num_rows, output meta_datao = datai-(K-1), floored at 0; otherwise meta_datao = datai.
REQ-033 SHALL, when enable is low, force state to IDLE, hold buf_we and win_shift at 0, set dvo = dvi, and pass meta_datao unchanged; after enable rises, processing SHALL resume only at the next FRAME_START.
REQ-034 SHALL set err[0] on a pixel outside ROW, on ROW_START in ROW, or on ROW_END outside ROW; ROW_START in ROW SHALL also clear col_addr without advancing wr_ptr.
REQ-035 SHALL drop pixels received outside ROW: no write, dvo 0.
REQ-036 SHALL clear err only on reset or FRAME_START.

Reset
REQ-037 SHALL asynchronously set state IDLE and clear col_addr, wr_ptr, row_cnt, header_addr, dvo, dtypeo, meta_datao and err; buf_we and win_shift SHALL read 0.
REQ-038 SHALL, on reset asserted mid-row, discard that row; the next frame SHALL start cleanly with no stale valid_row.

Structure
REQ-039 SHALL take DTYPE codes, `DTYPE_PIXEL_MASK and the Image_* header offsets from shared dtypes.v and SHALL define no local copies.
REQ-040 SHALL place the state encoding in the shared package as constants KSEQ_IDLE, KSEQ_FRAME and KSEQ_ROW.
REQ-041 SHALL be a single module; the buffers and window are instantiated by the parent (rowbuffer instances), and the window rotation mux lives in the parent.

Verification
REQ-042 SHALL verify: K=3, 4x5 frame -> dvo on pixels only in rows 2..3 and cols 2..4; buf_we sequence per row 01,10,01,10; rd_base 1,0,1,0.
REQ-043 SHALL verify: header num_cols=640 and num_rows=480 -> meta_datao 638 and 478; num_cols=1 -> 0.
REQ-044 SHALL verify: row of MAX_COLS+2 pixels -> col_addr holds 1287 and err[1]=1 until next FRAME_START.
REQ-045 SHALL verify: enable dropped mid-row for 3 cycles and then raised -> buf_we 0, dvo = dvi, and no writes until the next FRAME_START.
REQ-046 SHALL verify: ROW_START twice without ROW_END -> err[0]=1, col_addr=0, wr_ptr unchanged.
REQ-047 SHALL verify: resetb pulsed low mid-row (asynchronous, between edges) -> outputs 0 immediately and the next frame matches the scenario in REQ-042.

Source files
------------

// File: rtl/kernel_seq_pkg.sv
// kernel_seq_pkg
// Shared definitions for the kernel sequencer and its neighbours:
//   - stream word type codes (DTYPE_*), their width and the pixel type mask
//   - header word offsets that carry the image geometry (IMAGE_NUM_*)
//   - the sequencer state encoding (KSEQ_IDLE / KSEQ_FRAME / KSEQ_ROW)
// No ports; imported with "import kernel_seq_pkg::*;".
package kernel_seq_pkg;

    localparam int DTYPE_WIDTH = 16;

    // Word type codes are one-hot so pixel types can be recognised by a
    // mask, while control types are matched exactly.
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 16'h0001;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 16'h0002;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = 16'h0004;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = 16'h0008;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_RAW          = 16'h0010;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_RGB          = 16'h0020;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 16'h0100;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 16'h0200;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 16'h0030;

    // Header word positions (counted from the first HEADER word after
    // HEADER_START) that hold the frame geometry.
    localparam int               HEADER_ADDR_WIDTH = 6;
    localparam logic [5:0]       IMAGE_NUM_COLS    = 6'd2;
    localparam logic [5:0]       IMAGE_NUM_ROWS    = 6'd3;

    typedef enum logic [1:0] {
        KSEQ_IDLE  = 2'd0,
        KSEQ_FRAME = 2'd1,
        KSEQ_ROW   = 2'd2
    } kseq_state_e;

endpackage

// File: rtl/kernel_seq_if.sv
// kernel_seq_if
// Stream bundle between the upstream source and the kernel sequencer.
// Ports of the bundle:
//   dvi, dtypei, datai         : incoming word valid / type / data
//   dvo, dtypeo, meta_datao    : outgoing word valid / type / data
// Modports:
//   master : the stream source (drives the inputs, observes the outputs)
//   slave  : the kernel sequencer
interface kernel_seq_if #(
    parameter int DATA_WIDTH = 16
);

    logic                                   dvi;
    logic [kernel_seq_pkg::DTYPE_WIDTH-1:0] dtypei;
    logic [DATA_WIDTH-1:0]                  datai;
    logic                                   dvo;
    logic [kernel_seq_pkg::DTYPE_WIDTH-1:0] dtypeo;
    logic [DATA_WIDTH-1:0]                  meta_datao;

    modport master (
        output dvi, dtypei, datai,
        input  dvo, dtypeo, meta_datao
    );

    modport slave (
        input  dvi, dtypei, datai,
        output dvo, dtypeo, meta_datao
    );

endinterface

// File: rtl/kernel_seq.sv
// kernel_seq
// Sequences the K-1 row buffers and the KxK shift window of the kernel
// datapath. One row buffer is written per row (selected by wr_ptr); the
// parent reads the buffers in rotated order starting at rd_base.
// Ports:
//   clk        : sole clock, rising edge
//   resetb     : asynchronous active-low reset
//   strm       : stream bundle (kernel_seq_if.slave): dvi/dtypei/datai in,
//                dvo/dtypeo/meta_datao out, one clock of latency
//   enable     : 0 = bypass (stream passes through, no buffer activity)
//   col_addr   : shared row buffer address
//   buf_we     : one-hot row buffer write enable
//   rd_base    : index of the oldest buffer, feeding window row 0
//   win_shift  : shift the KxK window one column
//   err        : sticky flags, bit0 protocol error, bit1 column overflow
module kernel_seq #(
    parameter int KERNEL_SIZE    = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int MAX_COLS       = 1288,
    parameter int NUM_COLS_WIDTH = 11
) (
    input  logic                      clk,
    input  logic                      resetb,
    kernel_seq_if.slave               strm,
    input  logic                      enable,
    output logic [NUM_COLS_WIDTH-1:0] col_addr,
    output logic [KERNEL_SIZE-2:0]    buf_we,
    output logic [2:0]                rd_base,
    output logic                      win_shift,
    output logic [1:0]                err
);

    import kernel_seq_pkg::*;

    localparam int                        NBUF     = KERNEL_SIZE - 1;
    localparam logic [2:0]                NBUF3    = 3'(NBUF);
    localparam logic [2:0]                LAST_PTR = 3'(NBUF - 1);
    localparam logic [NUM_COLS_WIDTH-1:0] COL_LAST = NUM_COLS_WIDTH'(MAX_COLS - 1);
    localparam logic [NUM_COLS_WIDTH-1:0] KM1_COL  = NUM_COLS_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0]     KM1_DATA = DATA_WIDTH'(KERNEL_SIZE - 1);

    kseq_state_e                  state_q, state_d;
    logic [NUM_COLS_WIDTH-1:0]    col_addr_q, col_addr_d;
    logic [2:0]                   wr_ptr_q, wr_ptr_d;
    logic [2:0]                   row_cnt_q, row_cnt_d;
    logic [HEADER_ADDR_WIDTH-1:0] header_addr_q, header_addr_d;
    logic [1:0]                   err_q, err_d;
    logic                         dvo_q, dvo_d;
    logic [DTYPE_WIDTH-1:0]       dtypeo_q, dtypeo_d;
    logic [DATA_WIDTH-1:0]        meta_q, meta_d;

    logic isFrameStart, isFrameEnd, isRowStart, isRowEnd;
    logic isPixelType, pixelBeat;
    logic isHeaderStart, isHeaderWord, isGeometryWord;
    logic validRow, validCol;
    logic [DATA_WIDTH-1:0] headerAdjusted;

    // Decode the incoming word. Control and pixel events only count while
    // enabled; a pixel beat additionally needs the sequencer to be inside a
    // row. Header tracking follows the stream even in bypass so the header
    // position is never out of step with the data.
    always_comb begin
        isFrameStart   = strm.dvi & enable & (strm.dtypei == DTYPE_FRAME_START);
        isFrameEnd     = strm.dvi & enable & (strm.dtypei == DTYPE_FRAME_END);
        isRowStart     = strm.dvi & enable & (strm.dtypei == DTYPE_ROW_START);
        isRowEnd       = strm.dvi & enable & (strm.dtypei == DTYPE_ROW_END);
        isPixelType    = strm.dvi & enable & (|(strm.dtypei & DTYPE_PIXEL_MASK));
        pixelBeat      = isPixelType & (state_q == KSEQ_ROW);
        isHeaderStart  = strm.dvi & (strm.dtypei == DTYPE_HEADER_START);
        isHeaderWord   = strm.dvi & (strm.dtypei == DTYPE_HEADER);
        isGeometryWord = isHeaderWord &
                         ((header_addr_q == IMAGE_NUM_COLS) || (header_addr_q == IMAGE_NUM_ROWS));
        validRow       = (row_cnt_q >= NBUF3);
        validCol       = (col_addr_q >= KM1_COL);
        headerAdjusted = (strm.datai >= KM1_DATA) ? (strm.datai - KM1_DATA) : '0;
    end

    // Buffer write and window shift follow the pixel beat in the same
    // cycle, so the parent can use col_addr/wr_ptr as they stand now.
    always_comb begin
        buf_we    = pixelBeat ? (NBUF'(1) << wr_ptr_q) : '0;
        win_shift = pixelBeat;
        rd_base   = (wr_ptr_q == LAST_PTR) ? 3'd0 : (wr_ptr_q + 3'd1);
        col_addr  = col_addr_q;
        err       = err_q;
    end

    // Next-state logic for the sequencer and its registered outputs.
    // Bypass forces IDLE, so after enable returns nothing is written until
    // a fresh FRAME_START. A repeated ROW_START restarts the column count
    // but leaves the buffer pointer alone, and flags a protocol error.
    // The column counter sticks at the last buffer entry on overflow.
    always_comb begin
        state_d       = state_q;
        col_addr_d    = col_addr_q;
        wr_ptr_d      = wr_ptr_q;
        row_cnt_d     = row_cnt_q;
        err_d         = err_q;
        header_addr_d = header_addr_q;
        dvo_d         = 1'b0;
        dtypeo_d      = strm.dtypei;
        meta_d        = strm.datai;

        if (isHeaderStart) begin
            header_addr_d = '0;
        end else if (isHeaderWord) begin
            header_addr_d = header_addr_q + 6'd1;
        end

        if (!enable) begin
            state_d = KSEQ_IDLE;
            dvo_d   = strm.dvi;
        end else begin
            if (isFrameStart) begin
                state_d    = KSEQ_FRAME;
                col_addr_d = '0;
                wr_ptr_d   = '0;
                row_cnt_d  = '0;
                err_d      = '0;
            end else if (isFrameEnd) begin
                state_d = KSEQ_IDLE;
            end else if (isRowStart) begin
                col_addr_d = '0;
                if (state_q == KSEQ_FRAME) begin
                    state_d = KSEQ_ROW;
                end else if (state_q == KSEQ_ROW) begin
                    err_d[0] = 1'b1;
                end
            end else if (isRowEnd) begin
                if (state_q == KSEQ_ROW) begin
                    state_d   = KSEQ_FRAME;
                    wr_ptr_d  = (wr_ptr_q == LAST_PTR) ? 3'd0 : (wr_ptr_q + 3'd1);
                    row_cnt_d = (row_cnt_q == NBUF3) ? row_cnt_q : (row_cnt_q + 3'd1);
                end else begin
                    err_d[0] = 1'b1;
                end
            end else if (isPixelType) begin
                if (pixelBeat) begin
                    if (col_addr_q == COL_LAST) begin
                        err_d[1] = 1'b1;
                    end else begin
                        col_addr_d = col_addr_q + NUM_COLS_WIDTH'(1);
                    end
                end else begin
                    err_d[0] = 1'b1;
                end
            end

            if (!strm.dvi) begin
                dvo_d = 1'b0;
            end else if (isRowStart || isRowEnd) begin
                dvo_d = validRow;
            end else if (isPixelType) begin
                dvo_d = pixelBeat & validRow & validCol;
            end else begin
                dvo_d = 1'b1;
            end

            if (isGeometryWord) begin
                meta_d = headerAdjusted;
            end
        end
    end

    // All sequencer state and the stream outputs live in one register
    // bank; reset drops any partly received row and its row count.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= KSEQ_IDLE;
            col_addr_q    <= '0;
            wr_ptr_q      <= '0;
            row_cnt_q     <= '0;
            header_addr_q <= '0;
            err_q         <= '0;
            dvo_q         <= 1'b0;
            dtypeo_q      <= '0;
            meta_q        <= '0;
        end else begin
            state_q       <= state_d;
            col_addr_q    <= col_addr_d;
            wr_ptr_q      <= wr_ptr_d;
            row_cnt_q     <= row_cnt_d;
            header_addr_q <= header_addr_d;
            err_q         <= err_d;
            dvo_q         <= dvo_d;
            dtypeo_q      <= dtypeo_d;
            meta_q        <= meta_d;
        end
    end

    assign strm.dvo        = dvo_q;
    assign strm.dtypeo     = dtypeo_q;
    assign strm.meta_datao = meta_q;

endmodule

// File: tb/tb_kernel_seq.sv
// tb_kernel_seq
// Self-checking bench for kernel_seq with K=3, 16-bit data, 1288 columns.
// A table of directed vectors covers a 4x5 frame and header adjustment;
// hand-written sequences cover overflow, bypass, repeated ROW_START and
// an asynchronous reset in the middle of a row.
module tb_kernel_seq;

    import kernel_seq_pkg::*;

    localparam int K    = 3;
    localparam int DW   = 16;
    localparam int MAXC = 1288;
    localparam int NCW  = 11;

    logic           clk = 1'b0;
    logic           resetb;
    logic           enable;
    logic [NCW-1:0] colAddr;
    logic [K-2:0]   bufWe;
    logic [2:0]     rdBase;
    logic           winShift;
    logic [1:0]     err;

    int errors = 0;
    int checks = 0;
    int frameEnd = 0;

    kernel_seq_if #(.DATA_WIDTH(DW)) strm ();

    kernel_seq #(
        .KERNEL_SIZE   (K),
        .DATA_WIDTH    (DW),
        .MAX_COLS      (MAXC),
        .NUM_COLS_WIDTH(NCW)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .strm      (strm),
        .enable    (enable),
        .col_addr  (colAddr),
        .buf_we    (bufWe),
        .rd_base   (rdBase),
        .win_shift (winShift),
        .err       (err)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        dvi;
        logic [15:0] dtype;
        logic [15:0] data;
        logic        en;
        logic [1:0]  expWe;
        logic        expShift;
        logic        expDvo;
        logic [15:0] expMeta;
        logic [10:0] expCol;
        logic [2:0]  expRd;
        logic [1:0]  expErr;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic dv, input logic [15:0] dt, input logic [15:0] d,
                          input logic [1:0] we, input logic sh, input logic dvo,
                          input logic [15:0] meta, input logic [10:0] col,
                          input logic [2:0] rd, input logic [1:0] er);
        vec_t v;
        v.dvi = dv; v.dtype = dt; v.data = d; v.en = 1'b1;
        v.expWe = we; v.expShift = sh; v.expDvo = dvo; v.expMeta = meta;
        v.expCol = col; v.expRd = rd; v.expErr = er;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic dv, input logic [15:0] dt,
                                 input logic [15:0] d, input logic en);
        strm.dvi    = dv;
        strm.dtypei = dt;
        strm.datai  = d;
        enable      = en;
        #2;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic dv, input logic [15:0] dt,
                        input logic [15:0] d, input logic en);
        applyStimulus(dv, dt, d, en);
        clockEdge();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic runRange(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            vec_t v;
            v = vecs[i];
            applyStimulus(v.dvi, v.dtype, v.data, v.en);
            checkOutput($sformatf("vec%0d buf_we", i), 32'(bufWe), 32'(v.expWe));
            checkOutput($sformatf("vec%0d win_shift", i), 32'(winShift), 32'(v.expShift));
            clockEdge();
            checkOutput($sformatf("vec%0d dvo", i), 32'(strm.dvo), 32'(v.expDvo));
            checkOutput($sformatf("vec%0d dtypeo", i), 32'(strm.dtypeo), 32'(v.dtype));
            checkOutput($sformatf("vec%0d meta", i), 32'(strm.meta_datao), 32'(v.expMeta));
            checkOutput($sformatf("vec%0d col_addr", i), 32'(colAddr), 32'(v.expCol));
            checkOutput($sformatf("vec%0d rd_base", i), 32'(rdBase), 32'(v.expRd));
            checkOutput($sformatf("vec%0d err", i), 32'(err), 32'(v.expErr));
        end
    endtask

    // 4 rows x 5 columns: rows alternate buffers 0/1, output only once two
    // full rows are buffered and from the third column on.
    task automatic buildFrame();
        logic [2:0]  rdRow;
        logic [1:0]  weRow;
        addVec(1, DTYPE_FRAME_START, 16'h0, 2'b00, 0, 1, 16'h0, 11'd0, 3'd1, 2'b00);
        addVec(0, DTYPE_RAW, 16'h55, 2'b00, 0, 0, 16'h55, 11'd0, 3'd1, 2'b00);
        for (int r = 0; r < 4; r++) begin
            rdRow = (r % 2 == 0) ? 3'd1 : 3'd0;
            weRow = (r % 2 == 0) ? 2'b01 : 2'b10;
            addVec(1, DTYPE_ROW_START, 16'h0, 2'b00, 0, (r >= 2), 16'h0, 11'd0, rdRow, 2'b00);
            for (int c = 0; c < 5; c++) begin
                addVec(1, (c == 3) ? DTYPE_RGB : DTYPE_RAW, 16'(100 + 10 * r + c),
                       weRow, 1, (r >= 2 && c >= 2), 16'(100 + 10 * r + c),
                       11'(c + 1), rdRow, 2'b00);
            end
            addVec(1, DTYPE_ROW_END, 16'h0, 2'b00, 0, (r >= 2), 16'h0, 11'd5,
                   (r % 2 == 0) ? 3'd0 : 3'd1, 2'b00);
        end
        addVec(1, DTYPE_FRAME_END, 16'h0, 2'b00, 0, 1, 16'h0, 11'd5, 3'd1, 2'b00);
    endtask

    // Header words at positions 2 and 3 carry columns/rows and lose K-1.
    task automatic buildHeader();
        addVec(1, DTYPE_HEADER_START, 16'd0, 2'b00, 0, 1, 16'd0, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER, 16'd7, 2'b00, 0, 1, 16'd7, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER, 16'd9, 2'b00, 0, 1, 16'd9, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER, 16'd640, 2'b00, 0, 1, 16'd638, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER, 16'd480, 2'b00, 0, 1, 16'd478, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER, 16'd5, 2'b00, 0, 1, 16'd5, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER_START, 16'd0, 2'b00, 0, 1, 16'd0, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER, 16'd0, 2'b00, 0, 1, 16'd0, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER, 16'd0, 2'b00, 0, 1, 16'd0, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER, 16'd1, 2'b00, 0, 1, 16'd0, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER, 16'd2, 2'b00, 0, 1, 16'd0, 11'd5, 3'd1, 2'b00);
        addVec(1, DTYPE_HEADER, 16'd3, 2'b00, 0, 1, 16'd3, 11'd5, 3'd1, 2'b00);
    endtask

    // Main test flow.
    initial begin
        resetb      = 1'b1;
        enable      = 1'b1;
        strm.dvi    = 1'b0;
        strm.dtypei = '0;
        strm.datai  = '0;

        buildFrame();
        frameEnd = vecs.size();
        buildHeader();

        #2 resetb = 1'b0;
        #2;
        checkOutput("reset col_addr", 32'(colAddr), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset dvo", 32'(strm.dvo), 32'd0);
        checkOutput("reset meta", 32'(strm.meta_datao), 32'd0);
        checkOutput("reset dtypeo", 32'(strm.dtypeo), 32'd0);
        checkOutput("reset rd_base", 32'(rdBase), 32'd1);
        checkOutput("reset buf_we", 32'(bufWe), 32'd0);
        checkOutput("reset win_shift", 32'(winShift), 32'd0);
        #4 resetb = 1'b1;
        clockEdge();

        $display("[TB] table: 4x5 frame and header adjustment");
        runRange(0, vecs.size());

        $display("[TB] sequence: column overflow");
        step(1, DTYPE_FRAME_START, 16'd0, 1);
        step(1, DTYPE_ROW_START, 16'd0, 1);
        for (int i = 0; i < MAXC - 1; i++) step(1, DTYPE_RAW, 16'(i), 1);
        checkOutput("ovf col before last", 32'(colAddr), 32'd1287);
        checkOutput("ovf err before last", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, DTYPE_RAW, 16'hABCD, 1);
            checkOutput("ovf buf_we", 32'(bufWe), 32'd1);
            clockEdge();
            checkOutput("ovf col hold", 32'(colAddr), 32'd1287);
            checkOutput("ovf err", 32'(err), 32'd2);
        end
        step(1, DTYPE_ROW_END, 16'd0, 1);
        checkOutput("ovf col after row", 32'(colAddr), 32'd1287);
        checkOutput("ovf err after row", 32'(err), 32'd2);
        step(1, DTYPE_FRAME_START, 16'd0, 1);
        checkOutput("ovf err cleared", 32'(err), 32'd0);

        $display("[TB] sequence: enable dropped mid-row");
        step(1, DTYPE_ROW_START, 16'd0, 1);
        step(1, DTYPE_RAW, 16'd1, 1);
        step(1, DTYPE_RAW, 16'd2, 1);
        applyStimulus(1, DTYPE_RAW, 16'd3, 0);
        checkOutput("byp buf_we", 32'(bufWe), 32'd0);
        checkOutput("byp win_shift", 32'(winShift), 32'd0);
        clockEdge();
        checkOutput("byp dvo 1", 32'(strm.dvo), 32'd1);
        checkOutput("byp meta", 32'(strm.meta_datao), 32'd3);
        checkOutput("byp col hold", 32'(colAddr), 32'd2);
        step(0, DTYPE_RAW, 16'd4, 0);
        checkOutput("byp dvo 0", 32'(strm.dvo), 32'd0);
        applyStimulus(1, DTYPE_RAW, 16'd5, 0);
        checkOutput("byp buf_we 3", 32'(bufWe), 32'd0);
        clockEdge();
        checkOutput("byp dvo 3", 32'(strm.dvo), 32'd1);
        applyStimulus(1, DTYPE_RAW, 16'd6, 1);
        checkOutput("resume buf_we", 32'(bufWe), 32'd0);
        checkOutput("resume win_shift", 32'(winShift), 32'd0);
        clockEdge();
        checkOutput("resume dvo", 32'(strm.dvo), 32'd0);
        checkOutput("resume col", 32'(colAddr), 32'd2);
        checkOutput("resume err", 32'(err), 32'd1);
        step(1, DTYPE_ROW_START, 16'd0, 1);
        applyStimulus(1, DTYPE_RAW, 16'd7, 1);
        checkOutput("resume no write", 32'(bufWe), 32'd0);
        clockEdge();
        step(1, DTYPE_FRAME_START, 16'd0, 1);
        checkOutput("resume err cleared", 32'(err), 32'd0);
        step(1, DTYPE_ROW_START, 16'd0, 1);
        applyStimulus(1, DTYPE_RAW, 16'd8, 1);
        checkOutput("resume write", 32'(bufWe), 32'd1);
        clockEdge();

        $display("[TB] sequence: repeated ROW_START");
        step(1, DTYPE_FRAME_START, 16'd0, 1);
        step(1, DTYPE_ROW_START, 16'd0, 1);
        step(1, DTYPE_RAW, 16'd1, 1);
        step(1, DTYPE_ROW_END, 16'd0, 1);
        checkOutput("rs2 rd_base", 32'(rdBase), 32'd0);
        step(1, DTYPE_ROW_START, 16'd0, 1);
        step(1, DTYPE_RAW, 16'd2, 1);
        step(1, DTYPE_RAW, 16'd3, 1);
        checkOutput("rs2 col before", 32'(colAddr), 32'd2);
        step(1, DTYPE_ROW_START, 16'd0, 1);
        checkOutput("rs2 err", 32'(err), 32'd1);
        checkOutput("rs2 col", 32'(colAddr), 32'd0);
        checkOutput("rs2 rd_base hold", 32'(rdBase), 32'd0);
        applyStimulus(1, DTYPE_RAW, 16'd4, 1);
        checkOutput("rs2 buf_we", 32'(bufWe), 32'd2);
        checkOutput("rs2 win_shift", 32'(winShift), 32'd1);
        clockEdge();
        checkOutput("rs2 col next", 32'(colAddr), 32'd1);

        $display("[TB] sequence: reset mid-row");
        step(1, DTYPE_FRAME_START, 16'd0, 1);
        step(1, DTYPE_ROW_START, 16'd0, 1);
        step(1, DTYPE_ROW_END, 16'd0, 1);
        step(1, DTYPE_ROW_START, 16'd0, 1);
        step(1, DTYPE_ROW_END, 16'd0, 1);
        step(1, DTYPE_ROW_START, 16'd0, 1);
        step(1, DTYPE_RAW, 16'd1, 1);
        step(1, DTYPE_RAW, 16'd2, 1);
        applyStimulus(1, DTYPE_RAW, 16'd3, 1);
        checkOutput("pre-reset buf_we", 32'(bufWe), 32'd1);
        #1 resetb = 1'b0;
        #1;
        checkOutput("mid reset buf_we", 32'(bufWe), 32'd0);
        checkOutput("mid reset win_shift", 32'(winShift), 32'd0);
        checkOutput("mid reset col", 32'(colAddr), 32'd0);
        checkOutput("mid reset dvo", 32'(strm.dvo), 32'd0);
        checkOutput("mid reset meta", 32'(strm.meta_datao), 32'd0);
        checkOutput("mid reset rd_base", 32'(rdBase), 32'd1);
        checkOutput("mid reset err", 32'(err), 32'd0);
        #1 resetb = 1'b1;
        step(0, DTYPE_RAW, 16'd0, 1);
        runRange(0, frameEnd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
